// File: rtl/logic_unit_if.sv
// logic_unit_if: operand/result handshake bundle for logic_unit_pipe.
//   WIDTH       operand/result width
//   in_valid    producer -> unit, operand beat valid
//   in_ready    unit -> producer, beat can be accepted
//   A, B, op    operand beat (op selects the bitwise function)
//   out_valid   unit -> consumer, result beat valid
//   out_ready   consumer -> unit, result accepted
//   Y, zero     result beat and its all-zero flag
interface logic_unit_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             zero;
    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, Y, zero
    );
    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, Y, zero
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered 8-op bitwise unit with valid/ready handshakes and a 2-entry skid buffer.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        logic_unit_if.slave (in_valid/in_ready/A/B/op, out_valid/out_ready/Y/zero)
//   txn_count  completed output transfers, saturating; only counts when
//              LOGIC_UNIT_TXN_COUNT_EN is defined, otherwise tied to 0
//   op: 000 AND, 001 OR, 010 NOR, 011 NAND, 100 XOR, 101 XNOR, 110 NOT A, 111 PASS A
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_unit_if.slave      bus,
    output logic [CNT_W-1:0] txn_count
);
    logic [WIDTH-1:0] res, r0, r1;
    logic             r0_v, r1_v, rdy, push, pop;
    logic [1:0]       occ_n;

    // The result is computed at acceptance, so op is effectively captured with its beat.
    always_comb begin
        res = bus.op == 3'd0 ? bus.A & bus.B :
              bus.op == 3'd1 ? bus.A | bus.B :
              bus.op == 3'd2 ? ~(bus.A | bus.B) :
              bus.op == 3'd3 ? ~(bus.A & bus.B) :
              bus.op == 3'd4 ? bus.A ^ bus.B :
              bus.op == 3'd5 ? ~(bus.A ^ bus.B) :
              bus.op == 3'd6 ? ~bus.A : bus.A;
    end

    assign push  = bus.in_valid & rdy;
    assign pop   = r0_v & bus.out_ready;
    // push implies occupancy < 2, so the next occupancy never exceeds 2
    assign occ_n = {1'b0, r0_v} + {1'b0, r1_v} + {1'b0, push} - {1'b0, pop};

    // in_ready is registered from the next occupancy, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0   <= '0;
            r1   <= '0;
            r0_v <= 1'b0;
            r1_v <= 1'b0;
            rdy  <= 1'b0;
        end else begin
            rdy <= occ_n < 2'd2;
            if (pop && r1_v) begin
                r0   <= r1;
                r1_v <= 1'b0;
            end else if (pop || !r0_v) begin
                if (push) r0 <= res;
                r0_v <= push;
            end else if (push) begin
                r1   <= res;
                r1_v <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = r0_v;
    assign bus.Y         = r0;
    assign bus.zero      = ~|r0;

`ifdef LOGIC_UNIT_TXN_COUNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (pop && cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
    end
    assign txn_count = cnt;
`else
    assign txn_count = '0;
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe (WIDTH=8, CNT_W=2).
module tb_logic_unit_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] txn_count;
    int         total = 0;
    int         bad = 0;

    logic_unit_if #(.WIDTH(8)) bus ();

    logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic v, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = v;
        bus.op       = o;
        bus.A        = a;
        bus.B        = b;
    endtask

`ifdef LOGIC_UNIT_TXN_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic [7:0] sweep_exp [8] = '{8'hC0, 8'hFC, 8'h03, 8'h3F, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    logic [1:0] cnt_exp   [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        beat(1'b0, 3'd0, 8'h00, 8'h00);
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_y", 32'(bus.Y), 32'h00);
        chk("rst_zero", 32'(bus.zero), 32'd1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_count", 32'(txn_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // truth sweep, one result per cycle
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 3'(i), 8'hF0, 8'hCC);
            @(negedge clk);
            chk($sformatf("sweep_y%0d", i), 32'(bus.Y), 32'(sweep_exp[i]));
            chk($sformatf("sweep_zero%0d", i), 32'(bus.zero), 32'd0);
            chk($sformatf("sweep_v%0d", i), 32'(bus.out_valid), 32'd1);
        end

        // zero flag
        beat(1'b1, 3'd0, 8'hAA, 8'h55);
        @(negedge clk);
        chk("zero_and_y", 32'(bus.Y), 32'h00);
        chk("zero_and_z", 32'(bus.zero), 32'd1);
        beat(1'b1, 3'd2, 8'hFF, 8'hFF);
        @(negedge clk);
        chk("zero_nor_y", 32'(bus.Y), 32'h00);
        chk("zero_nor_z", 32'(bus.zero), 32'd1);
        beat(1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // backpressure
        bus.out_ready = 1'b0;
        beat(1'b1, 3'd0, 8'h0F, 8'hFF);
        @(negedge clk);
        chk("bp_ready1", 32'(bus.in_ready), 32'd1);
        beat(1'b1, 3'd1, 8'h10, 8'h01);
        @(negedge clk);
        chk("bp_ready2", 32'(bus.in_ready), 32'd0);
        beat(1'b1, 3'd4, 8'hFF, 8'hFF);
        @(negedge clk);
        chk("bp_ready3", 32'(bus.in_ready), 32'd0);
        chk("bp_y1", 32'(bus.Y), 32'h0F);
        chk("bp_v1", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_y2", 32'(bus.Y), 32'h11);
        chk("bp_ready4", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("bp_y3", 32'(bus.Y), 32'h00);
        chk("bp_z3", 32'(bus.zero), 32'd1);
        chk("bp_v3", 32'(bus.out_valid), 32'd1);
        beat(1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // stall stability while inputs wander (op may even be X while idle)
        bus.out_ready = 1'b0;
        beat(1'b1, 3'd4, 8'h5A, 8'h0F);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            beat(1'b0, 3'(i + 1), 8'(i * 37), 8'(~i));
            if (i == 2) bus.op = 3'bxxx;
            @(negedge clk);
            chk($sformatf("stall_y%0d", i), 32'(bus.Y), 32'h55);
            chk($sformatf("stall_z%0d", i), 32'(bus.zero), 32'd0);
            chk($sformatf("stall_v%0d", i), 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("stall_drain", 32'(bus.out_valid), 32'd0);

        // reset with two beats held
        bus.out_ready = 1'b0;
        beat(1'b1, 3'd7, 8'h81, 8'h00);
        @(negedge clk);
        beat(1'b1, 3'd7, 8'h42, 8'h00);
        @(negedge clk);
        beat(1'b0, 3'd0, 8'h00, 8'h00);
        chk("mr_full", 32'(bus.in_ready), 32'd0);
        chk("mr_y_before", 32'(bus.Y), 32'h81);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_y", 32'(bus.Y), 32'h00);
        chk("mr_zero", 32'(bus.zero), 32'd1);
        chk("mr_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rel_ready", 32'(bus.in_ready), 32'd1);
        chk("mr_rel_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        beat(1'b1, 3'd0, 8'hFF, 8'h3C);
        @(negedge clk);
        chk("mr_new_y", 32'(bus.Y), 32'h3C);
        chk("mr_new_v", 32'(bus.out_valid), 32'd1);
        beat(1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("mr_alone", 32'(bus.out_valid), 32'd0);

        // transfer counter from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cnt_rst", 32'(txn_count), 32'd0);
        for (int i = 0; i < 6; i++) begin
            beat(i < 5, 3'd1, 8'(i), 8'h80);
            @(negedge clk);
            chk($sformatf("cnt%0d", i), 32'(txn_count), CNT_ON ? 32'(cnt_exp[i]) : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
